// File: rtl/pixel_line_buffer.sv
// Raster-order line buffer that presents a LINE_COUNT-tall vertical pixel column
// with its frame coordinates, one cycle after each accepted pixel.
module pixel_line_buffer #(
    parameter int DATA_WIDTH   = 8,
    parameter int FRAME_WIDTH  = 10,
    parameter int FRAME_HEIGHT = 10,
    parameter int LINE_COUNT   = 6,
    parameter int COORD_WIDTH  = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             i_valid,
    input  logic [DATA_WIDTH-1:0]            i_pixel,
    input  logic                             i_sof,
    output logic                             o_valid,
    output logic [LINE_COUNT*DATA_WIDTH-1:0] o_column,
    output logic [COORD_WIDTH-1:0]           o_xcoord,
    output logic [COORD_WIDTH-1:0]           o_ycoord,
    output logic                             o_window_valid,
    output logic                             o_eol,
    output logic                             o_eof
);

    localparam int XW = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
    localparam int YW = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
    localparam int NL = LINE_COUNT - 1;

    logic [XW-1:0]                      x_cnt;
    logic [YW-1:0]                      y_cnt;
    logic [XW-1:0]                      x_p0;
    logic [YW-1:0]                      y_p0;
    logic                               last_x_p0;
    logic                               last_y_p0;
    logic [LINE_COUNT*DATA_WIDTH-1:0]   column_p0;
    logic [DATA_WIDTH-1:0]              line_mem [NL][FRAME_WIDTH];

    logic                               vld_p1;
    logic [LINE_COUNT*DATA_WIDTH-1:0]   column_p1;
    logic [COORD_WIDTH-1:0]             xcoord_p1;
    logic [COORD_WIDTH-1:0]             ycoord_p1;
    logic                               window_p1;
    logic                               eol_p1;
    logic                               eof_p1;

    // Stage p0: effective coordinate of the incoming pixel and the column read from the stores.
    always_comb begin
        x_p0      = i_sof ? '0 : x_cnt;
        y_p0      = i_sof ? '0 : y_cnt;
        last_x_p0 = (x_p0 == XW'(FRAME_WIDTH - 1));
        last_y_p0 = (y_p0 == YW'(FRAME_HEIGHT - 1));
        column_p0 = '0;
        column_p0[DATA_WIDTH-1:0] = i_pixel;
        for (int k = 1; k < LINE_COUNT; k++) begin
            column_p0[k*DATA_WIDTH +: DATA_WIDTH] = line_mem[k-1][x_p0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (i_valid) begin
            if (last_x_p0) begin
                x_cnt <= '0;
                y_cnt <= last_y_p0 ? '0 : y_p0 + 1'b1;
            end else begin
                x_cnt <= x_p0 + 1'b1;
                y_cnt <= y_p0;
            end
        end
    end

    // Stores are never cleared; rows older than the current frame are hidden by the window flag.
    always_ff @(posedge clk) begin
        if (i_valid && !reset) begin
            line_mem[0][x_p0] <= i_pixel;
            for (int k = 1; k < NL; k++) begin
                line_mem[k][x_p0] <= line_mem[k-1][x_p0];
            end
        end
    end

    // Stage p1: registered outputs; column and coordinates hold while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1    <= 1'b0;
            column_p1 <= '0;
            xcoord_p1 <= '0;
            ycoord_p1 <= '0;
            window_p1 <= 1'b0;
            eol_p1    <= 1'b0;
            eof_p1    <= 1'b0;
        end else begin
            vld_p1 <= i_valid;
            if (i_valid) begin
                column_p1 <= column_p0;
                xcoord_p1 <= COORD_WIDTH'(x_p0);
                ycoord_p1 <= COORD_WIDTH'(y_p0);
                window_p1 <= (32'(y_p0) >= 32'(LINE_COUNT - 1));
                eol_p1    <= last_x_p0;
                eof_p1    <= last_x_p0 && last_y_p0;
            end else begin
                window_p1 <= 1'b0;
                eol_p1    <= 1'b0;
                eof_p1    <= 1'b0;
            end
        end
    end

    assign o_valid        = vld_p1;
    assign o_column       = column_p1;
    assign o_xcoord       = xcoord_p1;
    assign o_ycoord       = ycoord_p1;
    assign o_window_valid = window_p1;
    assign o_eol          = eol_p1;
    assign o_eof          = eof_p1;

endmodule
